// File: rtl/rest_pkg.sv
// Shared types and constants for the coin/bottle return dispenser.
package rest_pkg;

  localparam int unsigned CNT_W           = 4;
  localparam int unsigned CNT_MAX         = 15;
  localparam int unsigned GAP_CYC_DEF     = 4;
  localparam int unsigned TIMEOUT_CYC_DEF = 64;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DISP_S = 3'd1,
    DISP5  = 3'd2,
    DISP1  = 3'd3,
    GAP    = 3'd4,
    FAULT  = 3'd5
  } state_t;

endpackage

// File: rtl/rest_counter.sv
// Saturating up/down pending-request counter; o_ovf_c flags a request lost at the ceiling.
module rest_counter
  import rest_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic [CNT_W-1:0] o_cnt_nxt_c,
  output logic             o_ovf_c
);

  logic [CNT_W-1:0] r_cnt;

  // Simultaneous inc and dec cancel, so a full counter loses nothing in that case.
  always_comb begin
    o_cnt_nxt_c = r_cnt;
    o_ovf_c     = 1'b0;
    if (i_inc && !i_dec) begin
      if (r_cnt == CNT_W'(CNT_MAX)) begin
        o_ovf_c = 1'b1;
      end else begin
        o_cnt_nxt_c = r_cnt + CNT_W'(1);
      end
    end else if (i_dec && !i_inc && (r_cnt != '0)) begin
      o_cnt_nxt_c = r_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= o_cnt_nxt_c;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/rest_dispenser.sv
// Serialises queued coin/bottle returns onto three motors with an inter-dispense gap,
// a per-dispense timeout that latches a fault, and a sticky overflow flag.
module rest_dispenser
  import rest_pkg::*;
#(
  parameter int unsigned GAP_CYC     = GAP_CYC_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic REST1,
  input  logic REST5,
  input  logic PLEACA_STICLA,
  input  logic SENZ1,
  input  logic SENZ5,
  input  logic SENZ_STICLA,
  output logic MOTOR1,
  output logic MOTOR5,
  output logic MOTOR_STICLA,
  output logic BUSY,
  output logic EROARE,
  output logic OVF
);

  localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int unsigned TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [GAP_W-1:0] r_gap;
  logic [GAP_W-1:0] w_gap_nxt;
  logic [TO_W-1:0]  r_to;
  logic [TO_W-1:0]  w_to_nxt;

  logic [CNT_W-1:0] w_p1;
  logic [CNT_W-1:0] w_p5;
  logic [CNT_W-1:0] w_ps;
  logic [CNT_W-1:0] w_p1_nxt;
  logic [CNT_W-1:0] w_p5_nxt;
  logic [CNT_W-1:0] w_ps_nxt;
  logic             w_ovf1;
  logic             w_ovf5;
  logic             w_ovfs;
  logic             w_dec1;
  logic             w_dec5;
  logic             w_decs;
  logic             w_done;

  logic r_motor1;
  logic r_motor5;
  logic r_motor_s;
  logic r_busy;
  logic r_err;
  logic r_ovf;

  // A dispense completes only on the sensor that matches the active chute.
  assign w_dec1 = (r_state == DISP1)  && SENZ1;
  assign w_dec5 = (r_state == DISP5)  && SENZ5;
  assign w_decs = (r_state == DISP_S) && SENZ_STICLA;
  assign w_done = w_dec1 || w_dec5 || w_decs;

  rest_counter u_cnt_1 (
    .clk         (clk),
    .reset       (reset),
    .i_inc       (REST1),
    .i_dec       (w_dec1),
    .o_cnt       (w_p1),
    .o_cnt_nxt_c (w_p1_nxt),
    .o_ovf_c     (w_ovf1)
  );

  rest_counter u_cnt_5 (
    .clk         (clk),
    .reset       (reset),
    .i_inc       (REST5),
    .i_dec       (w_dec5),
    .o_cnt       (w_p5),
    .o_cnt_nxt_c (w_p5_nxt),
    .o_ovf_c     (w_ovf5)
  );

  rest_counter u_cnt_s (
    .clk         (clk),
    .reset       (reset),
    .i_inc       (PLEACA_STICLA),
    .i_dec       (w_decs),
    .o_cnt       (w_ps),
    .o_cnt_nxt_c (w_ps_nxt),
    .o_ovf_c     (w_ovfs)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_gap   <= '0;
      r_to    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gap   <= w_gap_nxt;
      r_to    <= w_to_nxt;
    end
  end

  // Next state; a sensor pulse in the timeout cycle still counts as completion.
  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap;
    w_to_nxt    = r_to;
    case (r_state)
      IDLE: begin
        w_gap_nxt = '0;
        w_to_nxt  = '0;
        if (w_ps != '0) begin
          w_state_nxt = DISP_S;
        end else if (w_p5 != '0) begin
          w_state_nxt = DISP5;
        end else if (w_p1 != '0) begin
          w_state_nxt = DISP1;
        end
      end
      DISP_S, DISP5, DISP1: begin
        if (w_done) begin
          w_state_nxt = GAP;
          w_gap_nxt   = '0;
        end else if (r_to == TO_W'(TIMEOUT_CYC - 1)) begin
          w_state_nxt = FAULT;
        end else begin
          w_to_nxt = r_to + TO_W'(1);
        end
      end
      GAP: begin
        if (r_gap == GAP_W'(GAP_CYC - 1)) begin
          w_state_nxt = IDLE;
        end else begin
          w_gap_nxt = r_gap + GAP_W'(1);
        end
      end
      FAULT: begin
        w_state_nxt = FAULT;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are registered from next-cycle values so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_motor1  <= 1'b0;
      r_motor5  <= 1'b0;
      r_motor_s <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_motor1  <= (w_state_nxt == DISP1);
      r_motor5  <= (w_state_nxt == DISP5);
      r_motor_s <= (w_state_nxt == DISP_S);
      r_busy    <= (w_state_nxt != IDLE) || (|{w_p1_nxt, w_p5_nxt, w_ps_nxt});
      r_err     <= (w_state_nxt == FAULT);
      r_ovf     <= r_ovf || w_ovf1 || w_ovf5 || w_ovfs;
    end
  end

  assign MOTOR1       = r_motor1;
  assign MOTOR5       = r_motor5;
  assign MOTOR_STICLA = r_motor_s;
  assign BUSY         = r_busy;
  assign EROARE       = r_err;
  assign OVF          = r_ovf;

endmodule

// File: tb/tb_rest_dispenser.sv
// Directed and randomized bench for rest_dispenser against a queue-level reference model.
module tb_rest_dispenser;

  localparam int GAP = 4;
  localparam int TMO = 64;
  localparam int PH_IDLE  = 0;
  localparam int PH_SERVE = 1;
  localparam int PH_GAP   = 2;
  localparam int PH_FAULT = 3;
  // Item index order is also service priority: 0 = bottle, 1 = 5 lei, 2 = 1 leu.
  localparam bit [2:0] S  = 3'b001;
  localparam bit [2:0] F5 = 3'b010;
  localparam bit [2:0] L1 = 3'b100;
  localparam bit [2:0] NO = 3'b000;

  logic clk = 1'b0;
  logic reset, REST1, REST5, PLEACA_STICLA, SENZ1, SENZ5, SENZ_STICLA;
  logic MOTOR1, MOTOR5, MOTOR_STICLA, BUSY, EROARE, OVF;

  always #5 clk = ~clk;

  rest_dispenser #(.GAP_CYC(GAP), .TIMEOUT_CYC(TMO)) dut (
    .clk           (clk),
    .reset         (reset),
    .REST1         (REST1),
    .REST5         (REST5),
    .PLEACA_STICLA (PLEACA_STICLA),
    .SENZ1         (SENZ1),
    .SENZ5         (SENZ5),
    .SENZ_STICLA   (SENZ_STICLA),
    .MOTOR1        (MOTOR1),
    .MOTOR5        (MOTOR5),
    .MOTOR_STICLA  (MOTOR_STICLA),
    .BUSY          (BUSY),
    .EROARE        (EROARE),
    .OVF           (OVF)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: pending item counts plus what the dispenser is currently doing.
  int m_pend[3];
  int m_phase = PH_IDLE;
  int m_serv  = 0;
  int m_on    = 0;
  int m_gap   = 0;
  bit m_ovf   = 1'b0;

  int       act_q[$];
  bit [2:0] prev_mot = 3'b000;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pend_total();
    return m_pend[0] + m_pend[1] + m_pend[2];
  endfunction

  task automatic model_step(input bit rst, input bit [2:0] req, input bit [2:0] sen);
    int       old[3];
    bit [2:0] done;
    bit       found;
    if (rst) begin
      for (int i = 0; i < 3; i++) m_pend[i] = 0;
      m_phase = PH_IDLE;
      m_ovf   = 1'b0;
      return;
    end
    for (int i = 0; i < 3; i++) old[i] = m_pend[i];
    done  = 3'b000;
    found = 1'b0;
    case (m_phase)
      PH_IDLE: begin
        for (int i = 0; i < 3; i++) begin
          if (!found && old[i] > 0) begin
            found   = 1'b1;
            m_phase = PH_SERVE;
            m_serv  = i;
            m_on    = 0;
          end
        end
      end
      PH_SERVE: begin
        m_on++;
        if (sen[m_serv]) begin
          done[m_serv] = 1'b1;
          m_phase      = PH_GAP;
          m_gap        = GAP;
        end else if (m_on >= TMO) begin
          m_phase = PH_FAULT;
        end
      end
      PH_GAP: begin
        m_gap--;
        if (m_gap == 0) m_phase = PH_IDLE;
      end
      default: ;
    endcase
    for (int i = 0; i < 3; i++) begin
      if (req[i] && !done[i]) begin
        if (old[i] == 15) m_ovf = 1'b1;
        else m_pend[i] = old[i] + 1;
      end else if (done[i] && !req[i]) begin
        m_pend[i] = old[i] - 1;
      end
    end
  endtask

  function automatic int exp_out();
    bit [5:0] v;
    v[5] = (m_phase == PH_SERVE) && (m_serv == 0);
    v[4] = (m_phase == PH_SERVE) && (m_serv == 1);
    v[3] = (m_phase == PH_SERVE) && (m_serv == 2);
    v[2] = (m_phase != PH_IDLE) || (pend_total() > 0);
    v[1] = (m_phase == PH_FAULT);
    v[0] = m_ovf;
    return 32'(v);
  endfunction

  function automatic int exp_pend();
    return (m_pend[0] << 8) | (m_pend[1] << 4) | m_pend[2];
  endfunction

  // One clock: drive, step the model with the same inputs, then compare after the edge.
  task automatic cyc(input bit rst, input bit [2:0] req, input bit [2:0] sen);
    bit [2:0] mot;
    reset         = rst;
    PLEACA_STICLA = req[0];
    REST5         = req[1];
    REST1         = req[2];
    SENZ_STICLA   = sen[0];
    SENZ5         = sen[1];
    SENZ1         = sen[2];
    @(posedge clk);
    model_step(rst, req, sen);
    #1;
    chk("outputs", 32'({MOTOR_STICLA, MOTOR5, MOTOR1, BUSY, EROARE, OVF}), exp_out());
    chk("pending", 32'({dut.u_cnt_s.o_cnt, dut.u_cnt_5.o_cnt, dut.u_cnt_1.o_cnt}), exp_pend());
    mot = {MOTOR1, MOTOR5, MOTOR_STICLA};
    if (prev_mot == 3'b000 && mot != 3'b000) begin
      for (int i = 0; i < 3; i++) if (mot[i]) act_q.push_back(i);
    end
    prev_mot = mot;
  endtask

  // Answer each dispense with its sensor after two motor cycles until everything is served.
  task automatic serve_all(input int maxc);
    bit [2:0] sen;
    int       n = 0;
    while (n < maxc && !(m_phase == PH_IDLE && pend_total() == 0) && m_phase != PH_FAULT) begin
      sen = 3'b000;
      if (m_phase == PH_SERVE && m_on >= 1) sen[m_serv] = 1'b1;
      cyc(1'b0, NO, sen);
      n++;
    end
    chk("serve_all_in_budget", 32'(n < maxc), 1);
  endtask

  initial begin
    bit       rst;
    bit [2:0] req;
    bit [2:0] sen;

    // Reset wins over simultaneous pulses.
    cyc(1'b1, 3'b111, 3'b111);
    cyc(1'b1, NO, NO);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_motors", 32'({MOTOR_STICLA, MOTOR5, MOTOR1}), 0);
    chk("rst_flags", 32'({EROARE, OVF}), 0);

    // Single 5-lei return: motor two edges after the pulse, drops on the sensor edge.
    cyc(1'b0, F5, NO);
    chk("p5_e1_motor", 32'(MOTOR5), 0);
    chk("p5_e1_busy", 32'(BUSY), 1);
    cyc(1'b0, NO, NO);
    chk("p5_e2_motor", 32'(MOTOR5), 1);
    cyc(1'b0, NO, NO);
    cyc(1'b0, NO, NO);
    cyc(1'b0, NO, F5);
    chk("p5_drop", 32'(MOTOR5), 0);
    repeat (GAP - 1) cyc(1'b0, NO, NO);
    chk("p5_busy_in_gap", 32'(BUSY), 1);
    cyc(1'b0, NO, NO);
    chk("p5_busy_done", 32'(BUSY), 0);

    // Priority: bottle, then 5 lei, then 1 leu.
    act_q.delete();
    cyc(1'b0, 3'b111, NO);
    serve_all(300);
    chk("prio_count", act_q.size(), 3);
    for (int i = 0; i < 3; i++) chk("prio_order", (i < act_q.size()) ? act_q[i] : -1, i);

    // Saturation at 15 with sticky overflow, then drain.
    cyc(1'b1, NO, NO);
    repeat (17) cyc(1'b0, L1, NO);
    chk("sat_p1", 32'(dut.u_cnt_1.o_cnt), 15);
    chk("sat_ovf", 32'(OVF), 1);
    serve_all(400);
    chk("sat_busy", 32'(BUSY), 0);
    chk("sat_ovf_sticky", 32'(OVF), 1);

    // Request coincident with completion leaves the count unchanged.
    cyc(1'b1, NO, NO);
    cyc(1'b0, L1, NO);
    cyc(1'b0, L1, NO);
    chk("simul_pre_p1", 32'(dut.u_cnt_1.o_cnt), 2);
    cyc(1'b0, L1, L1);
    chk("simul_p1", 32'(dut.u_cnt_1.o_cnt), 2);
    chk("simul_motor1", 32'(MOTOR1), 0);

    // Timeout after 64 motor cycles, fault is absorbing but still counts requests.
    cyc(1'b1, NO, NO);
    cyc(1'b0, L1, NO);
    cyc(1'b0, NO, NO);
    chk("tmo_motor_on", 32'(MOTOR1), 1);
    repeat (TMO - 1) cyc(1'b0, NO, NO);
    chk("tmo_63_err", 32'(EROARE), 0);
    chk("tmo_63_motor", 32'(MOTOR1), 1);
    cyc(1'b0, NO, NO);
    chk("tmo_err", 32'(EROARE), 1);
    chk("tmo_motor_off", 32'(MOTOR1), 0);
    cyc(1'b0, 3'b111, L1);
    repeat (5) cyc(1'b0, NO, 3'b111);
    chk("fault_motors", 32'({MOTOR_STICLA, MOTOR5, MOTOR1}), 0);
    chk("fault_err", 32'(EROARE), 1);
    chk("fault_p1", 32'(dut.u_cnt_1.o_cnt), 2);
    cyc(1'b1, NO, NO);
    chk("fault_rst_err", 32'(EROARE), 0);
    chk("fault_rst_busy", 32'(BUSY), 0);

    // Sensor in the timeout cycle wins.
    cyc(1'b0, L1, NO);
    cyc(1'b0, NO, NO);
    repeat (TMO - 1) cyc(1'b0, NO, NO);
    cyc(1'b0, NO, L1);
    chk("tmo_race_err", 32'(EROARE), 0);
    chk("tmo_race_p1", 32'(dut.u_cnt_1.o_cnt), 0);
    repeat (GAP) cyc(1'b0, NO, NO);
    chk("tmo_race_idle", 32'(BUSY), 0);

    // Reset in the middle of a dispense.
    cyc(1'b0, F5 | L1, NO);
    cyc(1'b0, NO, NO);
    chk("mid_motor5", 32'(MOTOR5), 1);
    cyc(1'b1, F5, F5);
    chk("mid_rst_motors", 32'({MOTOR_STICLA, MOTOR5, MOTOR1}), 0);
    chk("mid_rst_pend", 32'({dut.u_cnt_s.o_cnt, dut.u_cnt_5.o_cnt, dut.u_cnt_1.o_cnt}), 0);

    // Random traffic including stray sensors and occasional resets.
    for (int k = 0; k < 2000; k++) begin
      rst = ($urandom_range(0, 299) == 0) || (m_phase == PH_FAULT && $urandom_range(0, 9) == 0);
      for (int i = 0; i < 3; i++) begin
        req[i] = ($urandom_range(0, 7) == 0);
        sen[i] = ($urandom_range(0, 2) == 0);
      end
      cyc(rst, req, sen);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
